// File: rtl/imem_pkg.sv
// Shared constants and the reset program image for the fetch-stage instruction memory.
package imem_pkg;
  localparam int IMEM_WORD_W   = 16;
  localparam logic [IMEM_WORD_W-1:0] NOP_WORD = 16'h0000;
  localparam int IMEM_INIT_LEN = 10;

  localparam logic [IMEM_WORD_W-1:0] IMEM_INIT [IMEM_INIT_LEN] = '{
    16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004,
    16'hA005, 16'hA006, 16'hA007, 16'hA008, 16'hA009
  };

  // Image word for array slot k; slots past the program hold NOPs.
  function automatic logic [IMEM_WORD_W-1:0] init_word(input int k);
    logic [IMEM_WORD_W-1:0] w;
    w = NOP_WORD;
    if (k >= 0 && k < IMEM_INIT_LEN) w = IMEM_INIT[k];
    return w;
  endfunction
endpackage

// File: rtl/instruction_mem.sv
// Instruction memory: byte-addressed 16-bit fetch, zero-latency combinational read, no backpressure.
// IMEM_WRITE_EN adds a synchronous write port; default build is a reset-loaded ROM.
module instruction_mem
  import imem_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            pcIn,
`ifdef IMEM_WRITE_EN
  input  logic                   wrEn,
  input  logic [15:0]            wrAddr,
  input  logic [IMEM_WORD_W-1:0] wrData,
`endif
  output logic [IMEM_WORD_W-1:0] instruction
);

  logic [IMEM_WORD_W-1:0] mem [DEPTH];
  logic [15:0]            rd_hi;
  logic                   rd_in_range;

  // Shift instead of slicing [15:AW+1] so DEPTH=32768 (empty upper field) still elaborates.
  assign rd_hi       = pcIn >> (AW + 1);
  assign rd_in_range = (rd_hi == 16'h0000);

`ifdef IMEM_WRITE_EN
  logic [15:0] wr_hi;
  logic        wr_in_range;

  assign wr_hi       = wrAddr >> (AW + 1);
  assign wr_in_range = (wr_hi == 16'h0000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= init_word(k);
    end else if (wrEn && wr_in_range) begin
      mem[wrAddr[AW:1]] <= wrData;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= init_word(k);
    end
  end
`endif

  always_comb begin
    instruction = NOP_WORD;
    if (rst && rd_in_range) instruction = mem[pcIn[AW:1]];
  end

endmodule

// File: tb/tb_instruction_mem.sv
// Randomized self-checking bench for instruction_mem against a word-array reference model.
module tb_instruction_mem;
  localparam int DEPTH = 64;

  logic        clk;
  logic        rst;
  logic [15:0] pcIn;
  logic [15:0] instruction;
`ifdef IMEM_WRITE_EN
  logic        wrEn;
  logic [15:0] wrAddr;
  logic [15:0] wrData;
`endif

  int n_cmp;
  int n_err;

  // Reference: plain array of words, indexed by byte address / 2.
  logic [15:0] ref_mem [DEPTH];

  instruction_mem #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .pcIn        (pcIn),
`ifdef IMEM_WRITE_EN
    .wrEn        (wrEn),
    .wrAddr      (wrAddr),
    .wrData      (wrData),
`endif
    .instruction (instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_reset();
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = (k < 10) ? (16'hA000 | 16'(k)) : 16'h0000;
  endtask

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    int word;
    word = int'(a) / 2;
    if (word >= DEPTH) return 16'h0000;
    return ref_mem[word];
  endfunction

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 2 * DEPTH + 40));
  endfunction

  task automatic read_at(input string tag, input logic [15:0] a);
    pcIn = a;
    #1;
    check(tag, instruction, rst ? ref_read(a) : 16'h0000);
  endtask

`ifdef IMEM_WRITE_EN
  // Drive a write before the edge, confirm the old word is still read, then the new one.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    wrEn = 1'b1; wrAddr = a; wrData = d; pcIn = a;
    #1;
    check("wr_same_cycle_old", instruction, ref_read(a));
    @(posedge clk);
    #1;
    wrEn = 1'b0;
    if (int'(a) / 2 < DEPTH) ref_mem[int'(a) / 2] = d;
    check("wr_after_edge", instruction, ref_read(a));
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    pcIn  = 16'h0000;
`ifdef IMEM_WRITE_EN
    wrEn = 1'b0; wrAddr = 16'h0000; wrData = 16'h0000;
`endif
    ref_reset();

    // Held in reset: output is NOP whatever the address.
    #1;
    check("reset_pc0", instruction, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      #10;
      pcIn = (i < 5) ? 16'h0000 : 16'(2 * i);
      #0;
      #1;
      check("reset_hold", instruction, 16'h0000);
    end

    // Release mid-cycle; reads valid immediately.
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      read_at("prog_sweep", 16'(2 * k));
      check("prog_word_const", instruction, 16'hA000 | 16'(k));
      #9;
    end

    read_at("pc20_nop", 16'd20);
    check("pc20_const", instruction, 16'h0000);
    read_at("pc3_odd", 16'd3);
    check("pc3_const", instruction, 16'hA001);
    read_at("pc_depth", 16'h0080);
    check("pc_depth_const", instruction, 16'h0000);
    read_at("pc_last", 16'h007F);
    read_at("pc_max", 16'hFFFF);

    // Asynchronous reset pulse mid-cycle.
    @(negedge clk);
    pcIn = 16'd6;
    #2 rst = 1'b0;
    #1 check("async_rst_drop", instruction, 16'h0000);
    #3 rst = 1'b1;
    #1 check("async_rst_release", instruction, 16'hA003);

`ifdef IMEM_WRITE_EN
    do_write(16'd4, 16'h1234);
    @(negedge clk);
    read_at("wr_readback", 16'd4);
    check("wr_readback_const", instruction, 16'h1234);
    #2 rst = 1'b0;
    ref_reset();
    #1 check("wr_rst_drop", instruction, 16'h0000);
    #2 rst = 1'b1;
    #1 check("wr_rst_restore", instruction, 16'hA002);

    do_write(16'h0100, 16'hDEAD);
    for (int a = 0; a <= 126; a += 2) begin
      read_at("sweep_after_oor", 16'(a));
      check("sweep_image", instruction, (a < 20) ? (16'hA000 | 16'(a / 2)) : 16'h0000);
    end

    for (int i = 0; i < 60; i++) begin
      do_write(rand_addr(), 16'($urandom));
      @(negedge clk);
      read_at("rand_rd_after_wr", rand_addr());
    end
`endif

    // Randomized fetches, occasionally with a reset pulse in between.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        #1 rst = 1'b0;
        ref_reset();
        read_at("rand_in_reset", rand_addr());
        #1 rst = 1'b1;
      end
      read_at("rand_fetch", rand_addr());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instruction_mem.md
Name: instruction_mem

Overview:
- Read-only instruction memory for the 16-bit CPU datapath, sitting in the fetch stage between the PC register and the instruction decode/IF-ID register.
- Takes a byte address (`pcIn`) and returns the 16-bit instruction word at that address combinationally.
- Array contents are (re)loaded from a fixed program image on reset.

Parameters:
- DEPTH, 64, number of 16-bit instruction words; power of two, 2..32768.
- AW, $clog2(DEPTH), word-index width; derived, do not override.

Ports:
- clk  input  1  system clock; rising edge used only by the optional write port and init state.
- rst  input  1  asynchronous, active-low reset; low clears and reloads the array.
- pcIn  input  16  byte address of the instruction, from PC.
- instruction  output  16  instruction word at `pcIn`.

Behaviour:
- Addressing: byte addresses; word index = pcIn[AW:1]; pcIn[0] ignored, so odd addresses read the even word below.
- Out of range: if pcIn[15:AW+1] is nonzero, the address is beyond DEPTH words and `instruction` = 16'h0000 (NOP). No wrap-around.
- Read: purely combinational from array and `pcIn`; zero-cycle latency; `instruction` follows `pcIn` within the same cycle.
- Reset, asserted (rst=0), asynchronous:
  - Every array word is loaded immediately from the package program image IMEM_INIT.
  - Words k = 0..9 = 16'hA000 | k; all words k >= 10 = 16'h0000.
  - `instruction` is forced to 16'h0000 while rst=0, regardless of `pcIn`.
- Reset release: reads valid in the same cycle rst goes high; no init delay.
- Reset mid-operation: output drops to 0 asynchronously; any contents written via the optional port are discarded and the image restored.
- No handshake; every cycle is a valid fetch.

Optional Feature:
- Macro IMEM_WRITE_EN.
- Defined: adds ports wrEn (in, 1), wrAddr (in, 16, byte address), wrData (in, 16).
  - On rising clk with rst=1 and wrEn=1 and wrAddr in range: word wrAddr[AW:1] <= wrData.
  - Out-of-range writes are ignored.
  - A read of the same word in the write cycle returns the old value; the new value appears after the edge.
- Undefined: no write ports; array is constant after reset (ROM); clk is unused.

Decomposition:
- Package imem_pkg: IMEM_WORD_W=16, NOP_WORD=16'h0000, IMEM_INIT_LEN=10, and the IMEM_INIT constant array (16'hA000..16'hA009).
- No sub-module; one flat module with the array, reset loader, read mux and range check.

Test Plan:
- rst=0, pcIn=0 -> instruction=16'h0000; hold for 100 ns, output stays 0.
- rst=1, then pcIn=0,2,4,...,18 every 10 ns -> instruction=16'hA000,A001,...,A009, each in the same cycle.
- rst=1, pcIn=20 -> 16'h0000; pcIn=3 -> 16'hA001 (bit 0 ignored); pcIn=16'h0080 (word 64 = DEPTH) -> 16'h0000.
- rst pulsed low asynchronously mid-cycle with pcIn=6 -> instruction=0 immediately; after release -> 16'hA003.
- IMEM_WRITE_EN: write 16'h1234 to wrAddr=4 -> next cycle pcIn=4 reads 16'h1234; rst pulse -> pcIn=4 reads 16'hA002.
- IMEM_WRITE_EN: wrAddr=16'h0100 (out of range) with wrEn=1 -> no word changes; full sweep 0..126 matches the image.
